// File: rtl/rtmq_osr_spi_tx.sv
// rtmq_osr_spi_tx: serialises a latched RTMQ output-shift-register frame MSB-first onto a mode-0 SPI bus.
// Optional sdi readback into rdb_dat is built only when RTMQ_SPI_RDBK_EN is defined.
module rtmq_osr_spi_tx #(
    parameter int unsigned W_FRM = 192,
    parameter int unsigned W_LEN = 8,
    parameter int unsigned DIV   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W_FRM-1:0] frm_dat,
    input  logic [W_LEN-1:0] frm_len,
    input  logic             trg,
    input  logic             sdi,
    output logic             busy,
    output logic             done,
    output logic             ovr,
    output logic             sclk,
    output logic             cs_n,
    output logic             sdo,
    output logic [W_FRM-1:0] rdb_dat
);
    localparam int unsigned      W_DIV    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W_DIV-1:0] HALF_END = W_DIV'(DIV - 1);
    localparam logic [W_LEN-1:0] LEN_MAX  = W_LEN'(W_FRM);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [W_FRM-1:0] shreg;
    logic [W_LEN-1:0] last_bit;
    logic [W_LEN-1:0] bcnt;
    logic [W_DIV-1:0] hcnt;
    logic [W_LEN-1:0] len_sel;
    logic             half_end;
    logic             accept;
    logic             rise;
    logic             fall;
    logic             last;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rise      = 1'b0;
        fall      = 1'b0;
        half_end  = (hcnt == HALF_END);
        last      = (bcnt == last_bit);
        len_sel   = (frm_len > LEN_MAX) ? LEN_MAX : frm_len;
        case (state)
            IDLE: begin
                if (trg && (frm_len != '0)) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                rise = half_end && !sclk;
                fall = half_end && sclk;
                if (fall && last) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (half_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            last_bit <= '0;
            bcnt     <= '0;
            hcnt     <= '0;
            sclk     <= 1'b0;
            cs_n     <= 1'b1;
            done     <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            done <= (state == GAP) && half_end;
            ovr  <= trg && (state != IDLE);
            if (state == IDLE) begin
                hcnt <= '0;
            end else begin
                hcnt <= half_end ? '0 : hcnt + W_DIV'(1);
            end
            if (accept) begin
                shreg    <= frm_dat;
                last_bit <= len_sel - W_LEN'(1);
                bcnt     <= '0;
                cs_n     <= 1'b0;
                sclk     <= 1'b0;
            end
            if (rise) begin
                sclk <= 1'b1;
            end
            // Clearing shreg on the last fall also forces sdo low for the gap and idle time.
            if (fall) begin
                sclk <= 1'b0;
                if (last) begin
                    cs_n  <= 1'b1;
                    shreg <= '0;
                end else begin
                    bcnt  <= bcnt + W_LEN'(1);
                    shreg <= {shreg[W_FRM-2:0], 1'b0};
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign sdo  = shreg[W_FRM-1];

`ifdef RTMQ_SPI_RDBK_EN
    logic [W_FRM-1:0] rdb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdb_q <= '0;
        end else if (accept) begin
            rdb_q <= '0;
        end else if (rise) begin
            rdb_q <= {rdb_q[W_FRM-2:0], sdi};
        end
    end

    assign rdb_dat = rdb_q;
`else
    logic unused_sdi;

    assign unused_sdi = sdi;
    assign rdb_dat    = '0;
`endif

endmodule

// File: tb/tb_rtmq_osr_spi_tx.sv
// Scoreboard bench for rtmq_osr_spi_tx: stimulus queues expected frames, a negedge monitor checks the bus.
// Define RTMQ_SPI_RDBK_EN for both bench and RTL to exercise readback.
module tb_rtmq_osr_spi_tx;
    localparam int unsigned W  = 192;
    localparam int unsigned WL = 8;
    localparam int unsigned D  = 2;

    typedef struct {
        int unsigned    n;
        logic [W-1:0]   data;
        int unsigned    tcyc;
        logic [W-1:0]   rdb;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  frm_dat = '0;
    logic [WL-1:0] frm_len = '0;
    logic          trg = 1'b0;
    logic          sdi;
    logic          busy, done, ovr, sclk, cs_n, sdo;
    logic [W-1:0]  rdb_dat;

    int unsigned   cyc = 0;
    int unsigned   n_chk = 0;
    int unsigned   n_pass = 0;
    int unsigned   ovr_exp = 0;
    int unsigned   ovr_seen = 0;
    exp_t          exp_q[$];

    logic          drv_on = 1'b0;
    int unsigned   drv_t0 = 0;
    int unsigned   drv_n = 0;
    logic [W-1:0]  drv_r = '0;

    rtmq_osr_spi_tx #(.W_FRM(W), .W_LEN(WL), .DIV(D)) dut (
        .clk(clk), .rst(rst), .frm_dat(frm_dat), .frm_len(frm_len), .trg(trg), .sdi(sdi),
        .busy(busy), .done(done), .ovr(ovr), .sclk(sclk), .cs_n(cs_n), .sdo(sdo), .rdb_dat(rdb_dat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input logic [W-1:0] act, input logic [W-1:0] want);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    endtask

    function automatic logic [W-1:0] rnd_frame();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [W-1:0] low_mask(input int unsigned n);
        logic [W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < W; i++) if (i < n) m[i] = 1'b1;
        return m;
    endfunction

    task automatic to_cyc(input int unsigned c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    // Caller sits just after a rising edge; trg is sampled at the next edge.
    task automatic send(input logic [W-1:0] d, input int unsigned l, input logic [W-1:0] r,
                        output int unsigned dc);
        exp_t        e;
        int unsigned n;
        n  = (l > W) ? W : l;
        dc = cyc + 1 + (2 * n + 1) * D;
        if (l != 0) begin
            e.n    = n;
            e.data = d >> (W - n);
            e.tcyc = cyc;
`ifdef RTMQ_SPI_RDBK_EN
            e.rdb  = r & low_mask(n);
`else
            e.rdb  = '0;
`endif
            exp_q.push_back(e);
            drv_t0 = cyc + 1;
            drv_n  = n;
            drv_r  = r;
            drv_on = 1'b1;
        end
        frm_dat = d;
        frm_len = WL'(l);
        trg     = 1'b1;
        @(posedge clk); #1;
        trg     = 1'b0;
        frm_dat = rnd_frame();
        frm_len = WL'($urandom);
    endtask

    task automatic pulse_ovr();
        frm_dat = rnd_frame();
        frm_len = WL'($urandom_range(1, 255));
        trg     = 1'b1;
        @(posedge clk); #1;
        trg = 1'b0;
        chk(ovr === 1'b1, "ovr_pulse", W'(ovr), W'(1));
        @(posedge clk); #1;
        chk(ovr === 1'b0, "ovr_clear", W'(ovr), W'(0));
        ovr_exp++;
    endtask

    // sdi bit k of the readback pattern is held across the whole k-th sclk period.
    always @(negedge clk) begin
        int unsigned off;
        if (drv_on && cyc >= drv_t0 && (cyc - drv_t0) < 2 * drv_n * D) begin
            off = (cyc - drv_t0) / (2 * D);
            sdi = drv_r[drv_n - 1 - off];
        end else begin
            sdi = 1'($urandom);
        end
    end

    logic         busy_q, sclk_q, done_q, had_frame;
    int unsigned  busy_cnt, cs_cnt, cs_hi, rises;
    logic [W-1:0] cap;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_q = 1'b0; sclk_q = 1'b0; done_q = 1'b0; had_frame = 1'b0;
            busy_cnt = 0; cs_cnt = 0; cs_hi = 0; rises = 0; cap = '0;
        end else begin
            if (busy && !busy_q) begin
                chk(exp_q.size() != 0, "busy_without_trg", W'(busy), W'(0));
                if (exp_q.size() != 0)
                    chk(cyc == exp_q[0].tcyc + 1, "start_cycle", W'(cyc), W'(exp_q[0].tcyc + 1));
                if (had_frame) chk(cs_hi >= D, "cs_gap", W'(cs_hi), W'(D));
                busy_cnt = 0; cs_cnt = 0; rises = 0; cap = '0;
            end
            if (busy) busy_cnt++;
            if (!cs_n) cs_cnt++;
            if (!cs_n && sclk && !sclk_q) begin
                cap = {cap[W-2:0], sdo};
                rises++;
            end
            if (cs_n) cs_hi++;
            else cs_hi = 0;
            if (ovr) ovr_seen++;
            if (done) begin
                chk(!done_q, "done_single", W'(done_q), W'(0));
                if (exp_q.size() == 0) begin
                    chk(1'b0, "spurious_done", W'(done), W'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk(cyc == e.tcyc + 1 + (2 * e.n + 1) * D, "done_cycle", W'(cyc),
                        W'(e.tcyc + 1 + (2 * e.n + 1) * D));
                    chk(!busy, "busy_at_done", W'(busy), W'(0));
                    chk(rises == e.n, "sclk_pulses", W'(rises), W'(e.n));
                    chk(cap == e.data, "sdo_bits", cap, e.data);
                    chk(busy_cnt == (2 * e.n + 1) * D, "busy_len", W'(busy_cnt), W'((2 * e.n + 1) * D));
                    chk(cs_cnt == 2 * e.n * D, "cs_low_len", W'(cs_cnt), W'(2 * e.n * D));
                    chk(cs_n && !sclk && !sdo, "bus_idle", W'({cs_n, sclk, sdo}), W'(3'b100));
                    chk(rdb_dat == e.rdb, "rdb_dat", rdb_dat, e.rdb);
                    had_frame = 1'b1;
                end
            end
            busy_q = busy; sclk_q = sclk; done_q = done;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned  dc, dc2, t, l;
        logic [W-1:0] d;
        repeat (3) @(posedge clk);
        #1;
        chk(busy === 1'b0, "rst_busy", W'(busy), W'(0));
        chk(done === 1'b0, "rst_done", W'(done), W'(0));
        chk(ovr === 1'b0, "rst_ovr", W'(ovr), W'(0));
        chk(sclk === 1'b0, "rst_sclk", W'(sclk), W'(0));
        chk(cs_n === 1'b1, "rst_cs_n", W'(cs_n), W'(1));
        chk(sdo === 1'b0, "rst_sdo", W'(sdo), W'(0));
        chk(rdb_dat === '0, "rst_rdb", rdb_dat, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        d = rnd_frame();
        d[W-1 -: 8] = 8'hA5;
        send(d, 8, W'(8'hCA), dc);
        to_cyc(dc + 3);

        send(rnd_frame(), 0, rnd_frame(), dc);
        chk(!busy && cs_n && !done, "len0_ignored", W'({busy, cs_n, done}), W'(3'b010));
        repeat (10) @(posedge clk);
        #1;
        chk(!busy && cs_n && !sclk, "len0_quiet", W'({busy, cs_n, sclk}), W'(3'b010));

        send(rnd_frame(), 250, rnd_frame(), dc);
        to_cyc(dc + 2);

        send(rnd_frame(), 40, rnd_frame(), dc);
        to_cyc(cyc + 30);
        pulse_ovr();
        to_cyc(dc + 1);

        send(rnd_frame(), 12, rnd_frame(), dc);
        to_cyc(dc);
        send(rnd_frame(), 20, rnd_frame(), dc2);
        to_cyc(dc2 + 2);

        send(rnd_frame(), 16, rnd_frame(), dc);
        t = dc - 1 - (2 * 16 + 1) * D;
        to_cyc(t + 1 + 10 * D + 1);
        exp_q.delete();
        drv_on = 1'b0;
        rst = 1'b1;
        #1;
        chk(cs_n && !sclk && !busy && !sdo, "abort_state", W'({cs_n, sclk, busy, sdo}), W'(4'b1000));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(rnd_frame(), 16, rnd_frame(), dc);
        to_cyc(dc + 4);

        for (int unsigned i = 0; i < 8; i++) begin
            l = $urandom_range(1, 255);
            send(rnd_frame(), l, rnd_frame(), dc);
            to_cyc(dc + $urandom_range(0, 4));
        end
        to_cyc(cyc + 2 * D + 6);

        chk(exp_q.size() == 0, "frames_outstanding", W'(exp_q.size()), W'(0));
        chk(ovr_seen == ovr_exp, "ovr_count", W'(ovr_seen), W'(ovr_exp));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
